// File: rtl/riscv_pkg.sv
// Shared core definitions: widths, ALU opcodes, forward selects.
// Also the control bundle carried from ID into EX.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REGW_DEFAULT = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EXM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef struct packed {
      logic       valid;
      logic       alu_src_imm;
      logic [3:0] alu_op;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
   } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, pipeline control, bypass sources
// and the operands/control presented to the ALU.
interface id_ex_stage_if #(
   parameter int XLEN = riscv_pkg::XLEN_DEFAULT,
   parameter int REGW = riscv_pkg::REGW_DEFAULT
);

   logic            id_valid;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic            id_use_rs1;
   logic            id_use_rs2;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic            id_alu_src_imm;
   logic [3:0]      id_alu_op;
   logic [REGW-1:0] id_rd;
   logic            id_reg_write;
   logic            id_mem_read;
   logic            id_mem_write;

   logic            stall_in;
   logic            flush_in;

   logic [REGW-1:0] exm_rd;
   logic            exm_reg_write;
   logic [XLEN-1:0] exm_result;
   logic [REGW-1:0] wb_rd;
   logic            wb_reg_write;
   logic [XLEN-1:0] wb_data;

   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_op;
   logic            ex_valid;
   logic [REGW-1:0] ex_rd;
   logic            ex_reg_write;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic [XLEN-1:0] ex_store_data;
   logic            load_use_stall;

   modport master (
      output id_valid, id_rs1, id_rs2,
      output id_use_rs1, id_use_rs2,
      output id_rs1_data, id_rs2_data,
      output id_imm, id_alu_src_imm,
      output id_alu_op, id_rd,
      output id_reg_write, id_mem_read,
      output id_mem_write,
      output stall_in, flush_in,
      output exm_rd, exm_reg_write,
      output exm_result,
      output wb_rd, wb_reg_write, wb_data,
      input  alu_a, alu_b, alu_op,
      input  ex_valid, ex_rd,
      input  ex_reg_write, ex_mem_read,
      input  ex_mem_write, ex_store_data,
      input  load_use_stall
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2,
      input  id_use_rs1, id_use_rs2,
      input  id_rs1_data, id_rs2_data,
      input  id_imm, id_alu_src_imm,
      input  id_alu_op, id_rd,
      input  id_reg_write, id_mem_read,
      input  id_mem_write,
      input  stall_in, flush_in,
      input  exm_rd, exm_reg_write,
      input  exm_result,
      input  wb_rd, wb_reg_write, wb_data,
      output alu_a, alu_b, alu_op,
      output ex_valid, ex_rd,
      output ex_reg_write, ex_mem_read,
      output ex_mem_write, ex_store_data,
      output load_use_stall
   );

endinterface

// File: rtl/fwd_unit.sv
// Bypass source select for one EX-stage source register.
// EX/MEM beats MEM/WB; x0 never takes a bypass.
module fwd_unit #(
   parameter int REGW = riscv_pkg::REGW_DEFAULT
) (
   input  logic [REGW-1:0] rs,
   input  logic [REGW-1:0] exm_rd,
   input  logic            exm_reg_write,
   input  logic [REGW-1:0] wb_rd,
   input  logic            wb_reg_write,
   output logic [1:0]      sel
);
   import riscv_pkg::*;

   logic exm_hit;
   logic wb_hit;

   assign exm_hit = exm_reg_write
                 && (exm_rd != '0)
                 && (exm_rd == rs);
   assign wb_hit  = wb_reg_write
                 && (wb_rd != '0)
                 && (wb_rd == rs);

   always_comb begin
      sel = FWD_RF;
      if (exm_hit) begin
         sel = FWD_EXM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and load-use bubbles.
// Operands to the ALU are resolved combinationally from the stored regs.
module id_ex_stage #(
   parameter int XLEN = riscv_pkg::XLEN_DEFAULT,
   parameter int REGW = riscv_pkg::REGW_DEFAULT
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);
   import riscv_pkg::*;

   id_ex_ctrl_t     ctrl_q;
   id_ex_ctrl_t     ctrl_d;
   logic [REGW-1:0] rs1_q;
   logic [REGW-1:0] rs2_q;
   logic [REGW-1:0] rd_q;
   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] rs2_data_q;
   logic [XLEN-1:0] imm_q;

   logic            lus;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            bubble;
   logic            load;
   logic [1:0]      sel_a;
   logic [1:0]      sel_b;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;

   // Hazard against a load sitting in EX, independent of stall_in.
   assign rs1_hit = bus.id_use_rs1
                 && (bus.id_rs1 == rd_q);
   assign rs2_hit = bus.id_use_rs2
                 && (bus.id_rs2 == rd_q);

   assign lus = !bus.flush_in
             && ctrl_q.valid
             && ctrl_q.mem_read
             && (rd_q != '0)
             && bus.id_valid
             && (rs1_hit || rs2_hit);

   assign bubble = bus.flush_in
                || (!bus.stall_in && lus);
   assign load   = !bus.flush_in
                && !bus.stall_in
                && !lus;

   always_comb begin
      ctrl_d             = '0;
      ctrl_d.valid       = bus.id_valid;
      ctrl_d.alu_src_imm = bus.id_alu_src_imm;
      ctrl_d.alu_op      = bus.id_alu_op;
      ctrl_d.reg_write   = bus.id_reg_write
                        && bus.id_valid;
      ctrl_d.mem_read    = bus.id_mem_read
                        && bus.id_valid;
      ctrl_d.mem_write   = bus.id_mem_write
                        && bus.id_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else if (bubble) begin
         ctrl_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else if (load) begin
         ctrl_q     <= ctrl_d;
         rs1_q      <= bus.id_rs1;
         rs2_q      <= bus.id_rs2;
         rd_q       <= bus.id_rd;
         rs1_data_q <= bus.id_rs1_data;
         rs2_data_q <= bus.id_rs2_data;
         imm_q      <= bus.id_imm;
      end
   end

   fwd_unit #(.REGW(REGW)) u_fwd_a (
      .rs            (rs1_q),
      .exm_rd        (bus.exm_rd),
      .exm_reg_write (bus.exm_reg_write),
      .wb_rd         (bus.wb_rd),
      .wb_reg_write  (bus.wb_reg_write),
      .sel           (sel_a)
   );

   fwd_unit #(.REGW(REGW)) u_fwd_b (
      .rs            (rs2_q),
      .exm_rd        (bus.exm_rd),
      .exm_reg_write (bus.exm_reg_write),
      .wb_rd         (bus.wb_rd),
      .wb_reg_write  (bus.wb_reg_write),
      .sel           (sel_b)
   );

   always_comb begin
      fwd_a = rs1_data_q;
      case (sel_a)
         FWD_EXM: fwd_a = bus.exm_result;
         FWD_WB:  fwd_a = bus.wb_data;
         default: fwd_a = rs1_data_q;
      endcase
   end

   always_comb begin
      fwd_b = rs2_data_q;
      case (sel_b)
         FWD_EXM: fwd_b = bus.exm_result;
         FWD_WB:  fwd_b = bus.wb_data;
         default: fwd_b = rs2_data_q;
      endcase
   end

   assign bus.alu_a          = fwd_a;
   assign bus.alu_b          = ctrl_q.alu_src_imm
                             ? imm_q : fwd_b;
   assign bus.ex_store_data  = fwd_b;
   assign bus.alu_op         = ctrl_q.alu_op;
   assign bus.ex_valid       = ctrl_q.valid;
   assign bus.ex_rd          = rd_q;
   assign bus.ex_reg_write   = ctrl_q.reg_write;
   assign bus.ex_mem_read    = ctrl_q.mem_read;
   assign bus.ex_mem_write   = ctrl_q.mem_write;
   assign bus.load_use_stall = lus;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: expected EX contents are queued as each
// instruction is driven and compared one cycle later.
module tb_id_ex_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();

   id_ex_stage #(.XLEN(32), .REGW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        v;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] st;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h",
                  tag, got, exp);
      end
   endtask

   task automatic id_drive(
      input logic v, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic u1,
      input logic u2, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] imm,
      input logic src, input logic [3:0] op,
      input logic [4:0] rd, input logic rw,
      input logic mr, input logic mw);
      bus.id_valid       = v;
      bus.id_rs1         = rs1;
      bus.id_rs2         = rs2;
      bus.id_use_rs1     = u1;
      bus.id_use_rs2     = u2;
      bus.id_rs1_data    = d1;
      bus.id_rs2_data    = d2;
      bus.id_imm         = imm;
      bus.id_alu_src_imm = src;
      bus.id_alu_op      = op;
      bus.id_rd          = rd;
      bus.id_reg_write   = rw;
      bus.id_mem_read    = mr;
      bus.id_mem_write   = mw;
   endtask

   task automatic id_clear();
      id_drive(0, 0, 0, 0, 0, 0, 0, 0, 0,
               ALU_AND, 0, 0, 0, 0);
   endtask

   task automatic fwd(input logic [4:0] er,
                      input logic ew,
                      input logic [31:0] eres,
                      input logic [4:0] wr,
                      input logic ww,
                      input logic [31:0] wd);
      bus.exm_rd        = er;
      bus.exm_reg_write = ew;
      bus.exm_result    = eres;
      bus.wb_rd         = wr;
      bus.wb_reg_write  = ww;
      bus.wb_data       = wd;
   endtask

   task automatic push(input logic v,
                       input logic [3:0] op,
                       input logic [4:0] rd,
                       input logic rw, input logic mr,
                       input logic mw,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] st);
      exp_t e;
      e.v = v; e.op = op; e.rd = rd;
      e.rw = rw; e.mr = mr; e.mw = mw;
      e.a = a; e.b = b; e.st = st;
      sbq.push_back(e);
   endtask

   task automatic push_bubble();
      push(0, ALU_AND, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      #1;
      if (sbq.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_valid"}, bus.ex_valid, e.v);
         chk({tag, "_op"}, bus.alu_op, e.op);
         chk({tag, "_rd"}, bus.ex_rd, e.rd);
         chk({tag, "_rw"}, bus.ex_reg_write, e.rw);
         chk({tag, "_mr"}, bus.ex_mem_read, e.mr);
         chk({tag, "_mw"}, bus.ex_mem_write, e.mw);
         chk({tag, "_a"}, bus.alu_a, e.a);
         chk({tag, "_b"}, bus.alu_b, e.b);
         chk({tag, "_st"}, bus.ex_store_data, e.st);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its bound");
      $fatal(1, "timeout");
   end

   initial begin
      id_clear();
      fwd(0, 0, 0, 0, 0, 0);
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
      rst_n = 1'b0;

      // reset state, with a live instruction waiting in ID
      id_drive(1, 1, 2, 1, 1, 9, 9, 0, 0,
               ALU_ADD, 3, 1, 0, 0);
      #7;
      chk("rst_valid", bus.ex_valid, 0);
      chk("rst_op", bus.alu_op, 0);
      chk("rst_rd", bus.ex_rd, 0);
      chk("rst_rw", bus.ex_reg_write, 0);
      chk("rst_a", bus.alu_a, 0);
      chk("rst_b", bus.alu_b, 0);
      chk("rst_st", bus.ex_store_data, 0);
      chk("rst_lus", bus.load_use_stall, 0);
      #1 rst_n = 1'b1;

      // basic capture
      id_drive(1, 1, 2, 1, 1, 1, 1, 0, 0,
               ALU_ADD, 3, 1, 0, 0);
      push(1, ALU_ADD, 3, 1, 0, 0, 1, 1, 1);
      step();
      fwd(0, 0, 0, 0, 0, 0);
      sb_check("t1_add");

      // EX/MEM bypass and its priority over MEM/WB
      id_drive(1, 5, 6, 1, 1, 40, 8, 0, 0,
               ALU_ADD, 7, 1, 0, 0);
      push(1, ALU_ADD, 7, 1, 0, 0, 12, 8, 8);
      step();
      fwd(5, 1, 12, 0, 0, 0);
      sb_check("t2_exm");
      fwd(5, 1, 12, 5, 1, 99);
      #1 chk("t2_exm_over_wb", bus.alu_a, 12);
      fwd(0, 0, 0, 5, 1, 99);
      #1 chk("t2_wb_only", bus.alu_a, 99);
      fwd(5, 0, 12, 0, 0, 0);
      #1 chk("t2_rf", bus.alu_a, 40);

      // x0 is never bypassed
      id_drive(1, 9, 0, 1, 1, 3, 0, 0, 0,
               ALU_OR, 8, 1, 0, 0);
      push(1, ALU_OR, 8, 1, 0, 0, 3, 0, 0);
      step();
      fwd(0, 1, 7, 0, 1, 55);
      sb_check("t3_x0");

      // load-use: bubble, then MEM/WB bypass of the load value
      id_drive(1, 2, 0, 1, 0, 100, 0, 4, 1,
               ALU_ADD, 4, 1, 1, 0);
      push(1, ALU_ADD, 4, 1, 1, 0, 100, 4, 0);
      step();
      fwd(0, 0, 0, 0, 0, 0);
      id_drive(1, 4, 5, 1, 1, 0, 2, 0, 0,
               ALU_ADD, 6, 1, 0, 0);
      sb_check("t4_lw");
      chk("t4_lus", bus.load_use_stall, 1);
      push_bubble();
      step();
      fwd(4, 1, 104, 0, 0, 0);
      sb_check("t4_bubble");
      chk("t4_lus_clear", bus.load_use_stall, 0);
      push(1, ALU_ADD, 6, 1, 0, 0, 17, 2, 2);
      step();
      fwd(0, 0, 0, 4, 1, 17);
      sb_check("t4_add_wb");

      // stall freezes the stage while ID keeps changing
      for (int i = 0; i < 3; i++) begin
         bus.stall_in = 1'b1;
         id_drive(1, 5'(10 + i), 5'(11 + i), 1, 1,
                  $urandom, $urandom, $urandom, 1,
                  ALU_SUB, 5'(20 + i), 1, 0, 1);
         push(1, ALU_ADD, 6, 1, 0, 0, 17, 2, 2);
         step();
         fwd(0, 0, 0, 4, 1, 17);
         sb_check("t5_stall");
      end

      // flush wins over stall
      bus.stall_in = 1'b1;
      bus.flush_in = 1'b1;
      push_bubble();
      step();
      bus.stall_in = 1'b0;
      bus.flush_in = 1'b0;
      fwd(0, 0, 0, 0, 0, 0);
      sb_check("t5_flush");

      // immediate operand
      id_drive(1, 1, 2, 1, 1, 20, 6, 10, 1,
               ALU_SUB, 9, 1, 0, 0);
      push(1, ALU_SUB, 9, 1, 0, 0, 20, 10, 6);
      step();
      fwd(0, 0, 0, 0, 0, 0);
      sb_check("t6_imm");

      // store data takes the bypass even with imm on B
      id_drive(1, 1, 3, 1, 1, 7, 5, 8, 1,
               ALU_ADD, 0, 0, 0, 1);
      push(1, ALU_ADD, 0, 0, 0, 1, 7, 8, 32'hdead);
      step();
      fwd(3, 1, 32'hdead, 0, 0, 0);
      sb_check("t7_store");

      // invalid slot: control bits masked, data captured
      id_drive(0, 1, 2, 1, 1, 5, 6, 0, 0,
               ALU_SUB, 11, 1, 1, 1);
      push(0, ALU_SUB, 11, 0, 0, 0, 5, 6, 6);
      step();
      fwd(0, 0, 0, 0, 0, 0);
      sb_check("t8_invalid");

      // flush suppresses the load-use request
      id_drive(1, 2, 0, 1, 0, 100, 0, 4, 1,
               ALU_ADD, 4, 1, 1, 0);
      push(1, ALU_ADD, 4, 1, 1, 0, 100, 4, 0);
      step();
      fwd(0, 0, 0, 0, 0, 0);
      id_drive(1, 4, 5, 1, 1, 0, 2, 0, 0,
               ALU_ADD, 6, 1, 0, 0);
      bus.flush_in = 1'b1;
      sb_check("t9_lw");
      chk("t9_lus_flush", bus.load_use_stall, 0);
      push_bubble();
      step();
      bus.flush_in = 1'b0;
      sb_check("t9_flush");

      // load-use asserted under stall; stall holds the load
      id_drive(1, 2, 0, 1, 0, 100, 0, 4, 1,
               ALU_ADD, 4, 1, 1, 0);
      push(1, ALU_ADD, 4, 1, 1, 0, 100, 4, 0);
      step();
      id_drive(1, 7, 4, 0, 1, 1, 0, 0, 0,
               ALU_ADD, 6, 1, 0, 0);
      bus.stall_in = 1'b1;
      sb_check("t10_lw");
      chk("t10_lus_stall", bus.load_use_stall, 1);
      push(1, ALU_ADD, 4, 1, 1, 0, 100, 4, 0);
      step();
      bus.stall_in = 1'b0;
      sb_check("t10_hold");
      chk("t10_lus_held", bus.load_use_stall, 1);
      push_bubble();
      step();
      id_clear();
      sb_check("t10_bubble");

      // asynchronous reset during a stall
      id_drive(1, 7, 8, 1, 1, 11, 22, 0, 0,
               ALU_OR, 5, 1, 0, 0);
      push(1, ALU_OR, 5, 1, 0, 0, 11, 22, 22);
      step();
      sb_check("t11_pre");
      bus.stall_in = 1'b1;
      id_clear();
      #2 rst_n = 1'b0;
      #1;
      chk("t11_rst_valid", bus.ex_valid, 0);
      chk("t11_rst_op", bus.alu_op, 0);
      chk("t11_rst_rd", bus.ex_rd, 0);
      chk("t11_rst_a", bus.alu_a, 0);
      #2 rst_n = 1'b1;
      bus.stall_in = 1'b0;
      id_drive(1, 7, 8, 1, 1, 33, 44, 0, 0,
               ALU_AND, 9, 1, 0, 0);
      push(1, ALU_AND, 9, 1, 0, 0, 33, 44, 44);
      step();
      sb_check("t11_after");

      chk("sb_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
